// File: rtl/key_loader.sv
// Key front-end: collects a variable-length key as WORD_W-bit words, LSB-first,
// zeroes every bit at or above the effective length, and hands it off via valid/ack.
module key_loader #(
  parameter int KEY_MAX = 160,
  parameter int WORD_W  = 32,
  parameter int LEN_W   = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   key_length_k_i,
  input  logic [WORD_W-1:0]  word_i,
  input  logic               word_valid_i,
  output logic               word_ready_o,
  output logic [KEY_MAX-1:0] key_o,
  output logic               key_valid_o,
  input  logic               key_ack_i,
  output logic               busy_o,
  output logic               len_err_o
);

  localparam int NW    = (KEY_MAX + WORD_W - 1) / WORD_W;
  localparam int CNT_W = $clog2(NW + 1);
  // one spare bit so KEY_MAX and k always compare without overflow
  localparam int LW    = (($clog2(KEY_MAX + 1) > LEN_W) ? $clog2(KEY_MAX + 1) : LEN_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [KEY_MAX-1:0] r_key, w_wr;
  logic [LW-1:0]      r_len, w_k, w_len;
  logic [CNT_W-1:0]   r_cnt, r_nw, w_nw;
  logic               r_err;
  logic               w_start, w_accept, w_last;

  assign w_k      = LW'(key_length_k_i);
  assign w_len    = (w_k > LW'(KEY_MAX)) ? LW'(KEY_MAX) : w_k;
  assign w_nw     = CNT_W'((32'(w_len) + WORD_W - 1) / WORD_W);
  assign w_start  = (r_state == S_IDLE) && start_i;
  assign w_accept = word_valid_i && (r_state == S_LOAD);
  assign w_last   = (r_cnt == r_nw - CNT_W'(1));

  // Bits of the current word slot, already clipped to the effective length.
  always_comb begin
    w_wr = '0;
    for (int i = 0; i < KEY_MAX; i++)
      w_wr[i] = (i / WORD_W == int'(r_cnt)) && (i < int'(r_len)) && word_i[i % WORD_W];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = (w_len == '0) ? S_DONE : S_LOAD;
      S_LOAD: if (w_accept && w_last) w_next = S_DONE;
      S_DONE: if (key_ack_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_key <= '0;
      r_len <= '0;
      r_nw  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_len <= w_len;
      r_nw  <= w_nw;
      r_err <= (w_k == '0) || (w_k > LW'(KEY_MAX));
      r_key <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      // register was cleared at start and each slot is written once, so OR suffices
      r_key <= r_key | w_wr;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign word_ready_o = (r_state == S_LOAD);
  assign key_valid_o  = (r_state == S_DONE);
  assign busy_o       = (r_state != S_IDLE);
  assign key_o        = r_key;
  assign len_err_o    = r_err;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed vector table, random vectors
// against a length-mask reference model, and an asynchronous mid-load reset.
module tb_key_loader;

  logic         clock_i = 1'b0;
  logic         reset_i, start_i, word_valid_i, key_ack_i;
  logic [7:0]   key_length_k_i;
  logic [31:0]  word_i;
  logic         word_ready_o, key_valid_o, busy_o, len_err_o;
  logic [159:0] key_o;

  int total = 0;
  int bad   = 0;

  key_loader #(.KEY_MAX(160), .WORD_W(32), .LEN_W(8)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .key_length_k_i(key_length_k_i), .word_i(word_i), .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o), .key_o(key_o), .key_valid_o(key_valid_o),
    .key_ack_i(key_ack_i), .busy_o(busy_o), .len_err_o(len_err_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    int           k;
    logic [159:0] words;
    int           offer;
    logic [15:0]  vpat;
    bit           poke;
    int           ackd;
    logic [159:0] exp_key;
    bit           exp_err;
    int           exp_acc;
  } vec_t;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit vbit(input logic [15:0] p, input int j);
    return (j >= 16) ? 1'b1 : p[j];
  endfunction

  // Reference: keep the first min(k,160) bits of the word stream.
  function automatic logic [159:0] model_key(input logic [159:0] w, input int k);
    logic [159:0] m;
    int L;
    L = (k > 160) ? 160 : k;
    m = '0;
    for (int i = 0; i < L; i++) m[i] = 1'b1;
    return w & m;
  endfunction

  function automatic vec_t mk(input int k, input logic [159:0] w, input int offer,
                              input logic [15:0] vpat, input bit poke, input int ackd,
                              input logic [159:0] ek, input bit ee, input int ea);
    vec_t v;
    v.k = k; v.words = w; v.offer = offer; v.vpat = vpat; v.poke = poke; v.ackd = ackd;
    v.exp_key = ek; v.exp_err = ee; v.exp_acc = ea;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int L, n, lat, seen, cyc, idx, acc;
    logic rdy;
    bit stable;
    L = (v.k > 160) ? 160 : v.k;
    n = (L + 31) / 32;
    lat = 1;
    if (n > 0) begin
      seen = 0;
      for (int j = 0; j < 64; j++) begin
        if (vbit(v.vpat, j)) seen++;
        if (seen == n) begin lat = j + 2; break; end
      end
    end
    @(negedge clock_i);
    start_i = 1'b1; key_length_k_i = v.k[7:0]; word_valid_i = 1'b0;
    @(negedge clock_i);
    start_i = 1'b0; cyc = 1; idx = 0; acc = 0;
    while (!key_valid_o && cyc < 40) begin
      if (v.poke && cyc == 2) begin start_i = 1'b1; key_length_k_i = 8'd5; end
      else start_i = 1'b0;
      word_valid_i = vbit(v.vpat, cyc - 1) && (idx < v.offer);
      word_i = (idx < 5) ? v.words[idx*32 +: 32] : 32'h0;
      rdy = word_ready_o;
      @(negedge clock_i);
      if (word_valid_i && rdy) begin acc++; idx++; end
      cyc++;
    end
    start_i = 1'b0;
    chk({tag, " latency"}, 160'(cyc), 160'(lat));
    chk({tag, " accepts"}, 160'(acc), 160'(v.exp_acc));
    chk({tag, " key"}, key_o, v.exp_key);
    chk({tag, " len_err"}, 160'(len_err_o), 160'(v.exp_err));
    chk({tag, " done busy/rdy"}, {busy_o, word_ready_o}, 2'b10);
    // any leftover words keep being offered while the ack is withheld
    word_valid_i = (idx < v.offer);
    word_i = (idx < 5) ? v.words[idx*32 +: 32] : 32'hFFFF_FFFF;
    stable = 1'b1;
    repeat (v.ackd) begin
      @(negedge clock_i);
      if (!key_valid_o || key_o !== v.exp_key || word_ready_o) stable = 1'b0;
    end
    chk({tag, " hold"}, 160'(stable), 160'(1));
    key_ack_i = 1'b1; start_i = 1'b1; key_length_k_i = 8'd9;
    @(negedge clock_i);
    key_ack_i = 1'b0; start_i = 1'b0; word_valid_i = 1'b0;
    chk({tag, " after ack"}, {key_valid_o, busy_o}, 2'b00);
    chk({tag, " retained"}, key_o, v.exp_key);
    @(negedge clock_i);
    chk({tag, " start@ack ignored"}, 160'(busy_o), 160'(0));
    if (cyc >= 40) begin
      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
    end
  endtask

  vec_t tbl[7];
  vec_t rv;
  logic [159:0] ones;

  initial begin
    ones = '1;
    reset_i = 1'b1; start_i = 1'b0; word_valid_i = 1'b0; key_ack_i = 1'b0;
    key_length_k_i = 8'd0; word_i = 32'h0;
    #12;
    chk("reset outputs", {key_o, key_valid_o, word_ready_o, busy_o, len_err_o}, '0);
    @(negedge clock_i);
    reset_i = 1'b0;

    tbl[0] = mk(128, {32'hDEADBEEF, 128'h0F0E0D0C_0B0A0908_07060504_03020100}, 4, 16'hFFFF, 0, 2,
                {32'h0, 128'h0F0E0D0C_0B0A0908_07060504_03020100}, 0, 4);
    tbl[1] = mk(100, ones, 5, 16'hFFFF, 0, 3, {60'h0, {100{1'b1}}}, 0, 4);
    tbl[2] = mk(200, ones, 5, 16'hFFFF, 0, 1, ones, 1, 5);
    tbl[3] = mk(0, ones, 5, 16'hFFFF, 0, 1, 160'h0, 1, 0);
    tbl[4] = mk(64, {96'hABCDEF01_23456789_ABCDEF01, 64'h22222222_11111111}, 4, 16'h0009, 1, 10,
                {96'h0, 64'h22222222_11111111}, 0, 2);
    tbl[5] = mk(33, ones, 5, 16'hFFFF, 0, 0, {127'h0, {33{1'b1}}}, 0, 2);
    tbl[6] = mk(160, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000001},
                5, 16'h5555, 0, 1,
                {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000001}, 0, 5);
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset after two of four words
    @(negedge clock_i);
    start_i = 1'b1; key_length_k_i = 8'd128;
    @(negedge clock_i);
    start_i = 1'b0; word_valid_i = 1'b1; word_i = 32'h11223344;
    @(negedge clock_i);
    word_i = 32'h55667788;
    @(negedge clock_i);
    word_valid_i = 1'b0;
    chk("pre-reset busy", 160'(busy_o), 160'(1));
    #2 reset_i = 1'b1;
    #1 chk("async reset", {key_o, key_valid_o, word_ready_o, busy_o, len_err_o}, '0);
    @(negedge clock_i);
    reset_i = 1'b0;
    run(mk(32, {128'h0, 32'hA5A5A5A5}, 1, 16'hFFFF, 0, 1, {128'h0, 32'hA5A5A5A5}, 0, 1), "post-reset");

    for (int r = 0; r < 12; r++) begin
      rv.k = int'($urandom_range(0, 255));
      rv.words = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rv.offer = 5;
      rv.vpat = 16'($urandom);
      rv.poke = 1'b0;
      rv.ackd = int'($urandom_range(0, 3));
      rv.exp_key = model_key(rv.words, rv.k);
      rv.exp_err = (rv.k == 0) || (rv.k > 160);
      rv.exp_acc = (((rv.k > 160) ? 160 : rv.k) + 31) / 32;
      run(rv, $sformatf("rnd%0d k=%0d", r, rv.k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_loader.md
Name: key_loader

Overview:
- Sequential, parametrised key front-end for the ASCON core.
- Receives a variable-length key as a stream of WORD_W-bit words over a valid/ready handshake and assembles it LSB-first into a KEY_MAX-bit register.
- Forces every bit at or above the programmed key length k to zero.
- Presents the finished key with a valid/ack handshake to the initialisation logic that builds the IV/state.

Parameters:
- KEY_MAX, 160: width of the assembled key register in bits.
- WORD_W, 32: width of one input key word in bits.
- LEN_W, 8: width of the key-length input.

Ports:
- clock_i  in  1  system clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request to begin loading a key; honoured only in IDLE.
- key_length_k_i  in  LEN_W  key length k in bits; sampled only when start_i is accepted.
- word_i  in  WORD_W  key word; word n carries key bits [n*WORD_W +: WORD_W].
- word_valid_i  in  1  word_i is valid.
- word_ready_o  out  1  loader accepts a word this cycle.
- key_o  out  KEY_MAX  assembled, length-masked key.
- key_valid_o  out  1  key_o is complete and stable.
- key_ack_i  in  1  consumer has taken key_o.
- busy_o  out  1  high whenever state is not IDLE.
- len_err_o  out  1  last accepted start had k==0 or k>KEY_MAX.

Behaviour:
- Reset (asynchronous, any state, including mid-load):
  - state=IDLE; key_o=0; key_valid_o=0; word_ready_o=0; busy_o=0; len_err_o=0.
  - Word counter and latched length cleared.
- Effective length L = min(k, KEY_MAX). Word count N = ceil(L/WORD_W), computed at start.
- IDLE:
  - word_ready_o=0.
  - On start_i: latch L and N; len_err_o <= (k==0 || k>KEY_MAX); clear key register to 0; counter <= 0.
  - If L==0, go to DONE. Otherwise go to LOAD.
- LOAD:
  - word_ready_o=1 combinationally from state.
  - On word_valid_i && word_ready_o, word_i is written to bits [cnt*WORD_W +: WORD_W]:
    - ANDed bitwise with the mask (bit i kept iff i < L);
    - bits beyond KEY_MAX-1 are discarded;
    - cnt increments.
  - The transfer with cnt==N-1 moves the state to DONE.
  - Without word_valid_i, state and register hold.
  - start_i is ignored.
- DONE:
  - key_valid_o=1; key_o stable; word_ready_o=0.
  - On key_ack_i, go to IDLE; key_valid_o is low from the next cycle.
  - key_o retains its value until the next accepted start or reset.
  - start_i is ignored, including when asserted in the same cycle as key_ack_i.
- Invariant: key_o[i]==0 for all i>=L at all times.
- Latency with word_valid_i held high:
  - start in cycle 0 → LOAD in cycle 1.
  - Words accepted in cycles 1..N.
  - key_valid_o high from cycle N+1.
  - For k==0: key_valid_o high in cycle 1.
- len_err_o is updated only at an accepted start and held until then.
- busy_o = (state != IDLE).

Test Plan:
- Defaults; start with k=128; words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with valid held high → 4 accepts on consecutive cycles; key_valid_o 5 cycles after start; key_o[127:0]=0x0F0E..0100; key_o[159:128]=0; len_err_o=0.
- k=100; four words 0xFFFFFFFF → exactly 4 accepts; key_o = 2^100-1 (bits 159:100 zero); fifth word offered is not accepted.
- k=200; five words 0xFFFFFFFF → len_err_o=1; 5 accepts; key_o all 160 bits set.
- k=0 → no word accepted (word_ready_o stays 0); key_valid_o=1 in cycle 1; key_o=0; len_err_o=1.
- k=64; word_valid_i toggled 1,0,0,1 and start_i pulsed during LOAD → only 2 accepts, start ignored; key_ack_i withheld 10 cycles → key_o/key_valid_o stable; ack → IDLE next cycle; key_o retained.
- Reset asserted asynchronously after 2 of 4 words (k=128) → all outputs 0 immediately, IDLE; new start with k=32 and one word 0xA5A5A5A5 → key_o=0xA5A5A5A5, upper bits 0.
